uart_frame_core: RTL and testbench

Parametrised full-duplex UART. It extends the fixed 8N1 receive/transmit logic to configurable data width, parity and stop bits. It adds an RX FIFO with a valid/ready interface, per-word parity and framing error flags, sticky overrun, and a valid/ready TX input in place of the button-triggered message. It sits between the board UART pins (Bluetooth module) and the display/control logic.

---
 rtl/uart_frame_core.sv | 147 ++++++++++++++
 tb/tb_uart_frame_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_core.sv
// uart_frame_core: parametrised full-duplex UART with an RX FIFO (valid/ready),
// per-word parity/framing flags, sticky overrun and a valid/ready transmitter.
module uart_frame_core #(
  parameter int CLKS_PER_BIT  = 234,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 rx_err_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [2:0] DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 1);
  localparam bit HAS_PAR = PARITY != 0;
  localparam logic ODD = PARITY == 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic rx_m, rx_s;
  state_t rs, rs_n, ts, ts_n;
  logic [CW-1:0] rcnt, tcnt;
  logic [2:0] ridx, tidx;
  logic [DATA_BITS-1:0] rsh, tsh;
  logic rpe, tpar, rtick, rmid, ttick, push, pop, wr, empty, full;
  logic [AW:0] wp, rp;
  logic [DATA_BITS+1:0] mem [RX_FIFO_DEPTH];
  logic [DATA_BITS+1:0] head;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {uart_rx, rx_m};

  assign rtick = rcnt == LAST;
  assign rmid = rcnt == HALF;
  assign push = rs == STOP && rtick;

  always_comb begin
    rs_n = rs;
    case (rs)
      IDLE:    if (!rx_s) rs_n = START;
      START:   if (rmid) rs_n = rx_s ? IDLE : DATA;
      DATA:    if (rtick && ridx == DLAST) rs_n = HAS_PAR ? PAR : STOP;
      PAR:     if (rtick) rs_n = STOP;
      STOP:    if (rtick) rs_n = IDLE;
      default: rs_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rs <= IDLE;
      rcnt <= '0;
      ridx <= '0;
      rsh <= '0;
      rpe <= 1'b0;
    end else begin
      rs <= rs_n;
      rcnt <= (rs == IDLE || rs != rs_n || rtick) ? '0 : rcnt + CW'(1);
      ridx <= (rs != rs_n) ? '0 : ridx + 3'(rtick);
      if (rs == DATA && rtick) rsh <= {rx_s, rsh[DATA_BITS-1:1]};
      if (rs == START) rpe <= 1'b0;
      else if (rs == PAR && rtick) rpe <= rx_s ^ (^rsh) ^ ODD;
    end

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign pop = !empty && rx_ready;
  assign wr = push && (!full || pop);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      rx_overrun <= (push && full && !pop) || (rx_overrun && !rx_err_clr);
    end

  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= {!rx_s, rpe, rsh};

  assign head = mem[rp[AW-1:0]];
  assign rx_valid = !empty;
  assign rx_data = empty ? '0 : head[DATA_BITS-1:0];
  assign rx_parity_err = !empty && head[DATA_BITS];
  assign rx_frame_err = !empty && head[DATA_BITS+1];

  assign ttick = tcnt == LAST;
  assign tx_ready = ts == IDLE;

  always_comb begin
    ts_n = ts;
    case (ts)
      IDLE:    if (tx_valid) ts_n = START;
      START:   if (ttick) ts_n = DATA;
      DATA:    if (ttick && tidx == DLAST) ts_n = HAS_PAR ? PAR : STOP;
      PAR:     if (ttick) ts_n = STOP;
      STOP:    if (ttick && tidx == SLAST) ts_n = IDLE;
      default: ts_n = IDLE;
    endcase
  end

  // The line level for the next bit is registered on the boundary that enters it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ts <= IDLE;
      tcnt <= '0;
      tidx <= '0;
      tsh <= '0;
      tpar <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      ts <= ts_n;
      tcnt <= (ts == IDLE || ttick) ? '0 : tcnt + CW'(1);
      tidx <= (ts != ts_n) ? '0 : tidx + 3'(ttick);
      if (ts == IDLE) begin
        uart_tx <= !tx_valid;
        if (tx_valid) begin
          tsh <= tx_data;
          tpar <= (^tx_data) ^ ODD;
        end
      end else if (ttick) begin
        uart_tx <= ts_n == DATA ? (ts == START ? tsh[0] : tsh[1]) : ts_n == PAR ? tpar : 1'b1;
        if (ts == DATA) tsh <= tsh >> 1;
      end
    end
endmodule

// File: tb/tb_uart_frame_core.sv
// tb_uart_frame_core: directed vectors for uart_frame_core configured as
// 16 clocks/bit, 8 data bits, even parity, 2 stop bits, 4-entry RX FIFO.
module tb_uart_frame_core;
  localparam int CPB = 16;

  typedef struct {
    logic [7:0] d;
    logic bp, bs, epe, efe;
  } vec_t;

  logic clk = 0, reset_n = 0, rx_drv = 1, loop = 0;
  logic tx_valid = 0, rx_ready = 0, rx_err_clr = 0;
  logic [7:0] tx_data = 0, rx_data;
  logic uart_rx, uart_tx, tx_ready, rx_parity_err, rx_frame_err, rx_valid, rx_overrun;
  int vecs = 0, fails = 0;

  assign uart_rx = loop ? uart_tx : rx_drv;
  always #5 clk = ~clk;

  uart_frame_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                    .RX_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .rx_err_clr(rx_err_clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx_drv = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Even parity frame; bp flips parity, bs drives the first stop bit low
  task automatic send_rx(input logic [7:0] d, input logic bp, input logic bs);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time((^d) ^ bp);
    bit_time(!bs);
    bit_time(1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rx_valid_timeout", rx_valid, 1);
  endtask

  task automatic pop();
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
  endtask

  task automatic wait_tx_ready();
    int n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_timeout", tx_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [11:0] exp_bits;
    int lowcnt;
    tbl[0] = '{8'h00, 0, 0, 0, 0};
    tbl[1] = '{8'hFF, 0, 0, 0, 0};
    tbl[2] = '{8'h01, 1, 0, 1, 0};
    tbl[3] = '{8'h55, 0, 1, 0, 1};
    tbl[4] = '{8'h80, 1, 1, 1, 1};
    tbl[5] = '{8'hC3, 0, 0, 0, 0};

    #12;
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_flags", {rx_parity_err, rx_frame_err}, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);

    @(negedge clk);
    fork
      send_rx(8'hA5, 0, 0);
      begin
        int k = 0;
        @(posedge clk);
        #1;
        while (!rx_valid && k < 400) begin
          @(posedge clk);
          k++;
          #1;
        end
        chk("rx_latency", k, 171);
      end
    join
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_flags", {rx_parity_err, rx_frame_err}, 0);
    pop();
    chk("a5_popped", rx_valid, 0);

    for (int i = 0; i < 6; i++) begin
      fork
        send_rx(tbl[i].d, tbl[i].bp, tbl[i].bs);
        wait_valid();
      join
      chk("tbl_data", rx_data, tbl[i].d);
      chk("tbl_parity_err", rx_parity_err, tbl[i].epe);
      chk("tbl_frame_err", rx_frame_err, tbl[i].efe);
      pop();
      chk("tbl_popped", rx_valid, 0);
    end

    loop = 1;
    exp_bits = {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
    lowcnt = 0;
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1;
    @(posedge clk);
    for (int c = 0; c < 192; c++) begin
      @(negedge clk);
      if (!tx_ready) lowcnt++;
      if (c % 16 == 8) chk("tx_bit", uart_tx, exp_bits[c/16]);
    end
    chk("tx_ready_low_cycles", lowcnt, 192);
    @(negedge clk);
    chk("tx_ready_back", tx_ready, 1);
    chk("tx_idle_gap", uart_tx, 1);
    @(negedge clk);
    chk("tx_next_start_ready", tx_ready, 0);
    chk("tx_next_start_line", uart_tx, 0);
    tx_valid = 0;
    wait_valid();
    chk("loop1_data", rx_data, 8'h3C);
    chk("loop1_flags", {rx_parity_err, rx_frame_err}, 0);
    pop();
    wait_valid();
    chk("loop2_data", rx_data, 8'h3C);
    pop();
    wait_tx_ready();
    repeat (4) @(negedge clk);
    loop = 0;

    for (int i = 0; i < 5; i++) begin
      send_rx(8'(8'h10 + i), 0, 0);
      if (i == 3) chk("overrun_early", rx_overrun, 0);
    end
    chk("overrun_set", rx_overrun, 1);
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", rx_data, 8'(8'h10 + i));
      pop();
    end
    chk("fifo_drained", rx_valid, 0);
    chk("overrun_sticky", rx_overrun, 1);
    rx_err_clr = 1;
    @(negedge clk);
    rx_err_clr = 0;
    chk("overrun_cleared", rx_overrun, 0);

    rx_drv = 0;
    repeat (3) @(negedge clk);
    rx_drv = 1;
    repeat (40) @(negedge clk);
    chk("glitch_no_push", rx_valid, 0);
    send_rx(8'h5A, 0, 0);
    chk("after_glitch_valid", rx_valid, 1);
    chk("after_glitch_data", rx_data, 8'h5A);

    loop = 1;
    @(negedge clk);
    tx_data = 8'h96;
    tx_valid = 1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 0;
    repeat (72) @(negedge clk);
    chk("mid_frame_bit3", uart_tx, 0);
    reset_n = 0;
    #1;
    chk("async_rst_uart_tx", uart_tx, 1);
    chk("async_rst_tx_ready", tx_ready, 1);
    chk("async_rst_fifo_empty", rx_valid, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    tx_data = 8'h96;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    tx_data = 8'hFF;
    wait_valid();
    chk("clean_frame_data", rx_data, 8'h96);
    chk("clean_frame_flags", {rx_parity_err, rx_frame_err}, 0);
    pop();
    wait_tx_ready();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
